// File: rtl/mp_addsub_seq.sv
// ----------------------------------------------------------------------------
// mp_addsub_seq
//
// Sequential multi-precision adder/subtractor for 513-bit unsigned operands.
// The operation walks the operands one LIMB_W-bit limb per clock, rippling
// the carry between limbs through a single register, and produces a 514-bit
// registered result together with a one-cycle done pulse.
//
//   add      : result = in_a + in_b              (bit 513 is the carry-out)
//   subtract : result = (in_a - in_b) mod 2^514  (bit 513 set iff in_a < in_b)
//
// Ports
//   clk       in   1    rising-edge clock
//   reset     in   1    synchronous, active-high reset
//   start     in   1    request, only looked at while idle
//   subtract  in   1    0 = add, 1 = in_a - in_b; captured with start
//   in_a      in   513  operand A (unsigned); captured with start
//   in_b      in   513  operand B (unsigned); captured with start
//   result    out  514  registered sum/difference, held until next completion
//   done      out  1    one-cycle pulse, result valid while high
//
// Timing: start sampled at edge T gives done high between edge T+LIMBS and
// edge T+LIMBS+1. A new start may be accepted in the done cycle, so
// back-to-back throughput is one operation per LIMBS+1 cycles.
// ----------------------------------------------------------------------------
module mp_addsub_seq #(
    parameter int LIMB_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [512:0] in_a,
    input  logic [512:0] in_b,
    output logic [513:0] result,
    output logic         done
);

    localparam int OP_W  = 513;
    localparam int RES_W = 514;
    localparam int LIMBS = (RES_W + LIMB_W - 1) / LIMB_W;
    localparam int EXT   = LIMBS * LIMB_W;
    localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMBS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Operands and accumulator are kept as arrays of limbs so the current
    // limb is selected directly by the counter.
    typedef logic [LIMBS-1:0][LIMB_W-1:0] limbs_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    limbs_t           op_a;
    limbs_t           op_b;
    limbs_t           acc;

    limbs_t           acc_next;
    logic [LIMB_W:0]  limb_sum;
    logic [EXT-1:0]   acc_flat;
    logic             unused_acc_hi;

    // One limb of the ripple: LIMB_W-bit sum plus carry-out in the MSB.
    function automatic logic [LIMB_W:0] limb_add(
        input logic [LIMB_W-1:0] a,
        input logic [LIMB_W-1:0] b,
        input logic              cin
    );
        return {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    endfunction

    // Zero-extend a 513-bit operand to the full limb-aligned width.
    function automatic limbs_t zext(input logic [OP_W-1:0] v);
        return limbs_t'({{(EXT-OP_W){1'b0}}, v});
    endfunction

    // Current limb's sum and the accumulator as it will look once this limb
    // is written; the final edge loads result from this so the last limb is
    // included without an extra cycle.
    always_comb begin
        limb_sum      = limb_add(op_a[cnt], op_b[cnt], carry);
        acc_next      = acc;
        acc_next[cnt] = limb_sum[LIMB_W-1:0];
    end

    assign acc_flat = acc_next;

    // Accumulator bits above bit 513 only exist because of limb alignment;
    // they never reach the result.
    assign unused_acc_hi = ^acc_flat[EXT-1:RES_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B over the full
                        // extended width and seed the carry with 1. The
                        // low 514 bits are then (A - B) mod 2^514.
                        op_a  <= zext(in_a);
                        op_b  <= subtract ? ~zext(in_b) : zext(in_b);
                        carry <= subtract;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    carry <= limb_sum[LIMB_W];
                    if (cnt == LAST) begin
                        result <= acc_flat[RES_W-1:0];
                        done   <= 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// ----------------------------------------------------------------------------
// tb_mp_addsub_seq
//
// Directed bench for mp_addsub_seq at the default LIMB_W = 64 (9 limbs):
// reset state, single operations with latency and hold checks, carry and
// borrow extremes, busy rejection with toggling start, continuous start,
// and reset in the middle of an operation.
// ----------------------------------------------------------------------------
module tb_mp_addsub_seq;

    localparam int LAT = 9;

    logic         clk;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [512:0] in_a;
    logic [512:0] in_b;
    logic [513:0] result;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [512:0] MAX_A = {513{1'b1}};

    mp_addsub_seq #(
        .LIMB_W(64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [513:0] obs, input logic [513:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: start for a single edge, scramble inputs while busy,
    // then check latency, result, single-cycle done and result hold.
    task automatic run_op(input string tag, input logic [512:0] a, input logic [512:0] b,
                          input logic sub, input logic [513:0] exp);
        int n;
        in_a     = a;
        in_b     = b;
        subtract = sub;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        subtract = ~sub;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 514'(n), 514'(LAT));
        check({tag, " result"}, result, exp);
        tick();
        check({tag, " done_low"}, {513'b0, done}, 514'(0));
        check({tag, " hold"}, result, exp);
    endtask

    // mode 0: start and operands toggle every cycle (busy rejection)
    // mode 1: start held high, operands change every cycle
    task automatic stream(input string tag, input int mode, input int ncyc);
        logic         m_idle;
        int           m_left;
        logic         exp_done;
        logic [513:0] m_exp;
        int           ndone;
        m_idle = 1'b1;
        m_left = 0;
        m_exp  = '0;
        ndone  = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (mode == 0) begin
                start    = (k % 2 == 1);
                in_a     = (k % 2 == 1) ? MAX_A : '0;
                in_b     = (k % 2 == 1) ? MAX_A : '0;
                subtract = (k % 2 == 1);
            end else begin
                start    = 1'b1;
                in_a     = 513'(1000 + k);
                in_b     = 513'(300 * k);
                subtract = ((k / 10) % 2 == 1);
            end
            // reference: sample inputs as the edge will
            exp_done = 1'b0;
            if (m_idle) begin
                if (start) begin
                    m_idle = 1'b0;
                    m_left = LAT;
                    m_exp  = subtract ? ({1'b0, in_a} - {1'b0, in_b})
                                      : ({1'b0, in_a} + {1'b0, in_b});
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    exp_done = 1'b1;
                    m_idle   = 1'b1;
                end
            end
            tick();
            check($sformatf("%s done k=%0d", tag, k), {513'b0, done}, {513'b0, exp_done});
            if (done === 1'b1) ndone++;
            if (exp_done) check($sformatf("%s result k=%0d", tag, k), result, m_exp);
        end
        start = 1'b0;
        check({tag, " done_count"}, 514'(ndone), 514'(4));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) tick();
        check("reset done", {513'b0, done}, 514'(0));
        check("reset result", result, 514'(0));

        // start together with reset release: first edge after reset accepts it
        reset = 1'b0;
        run_op("add_1_1", 513'(1), 513'(1), 1'b0, 514'(2));
        run_op("ripple", MAX_A, 513'(1), 1'b0, {1'b1, 513'b0});
        run_op("sub_0_1", 513'(0), 513'(1), 1'b1, {514{1'b1}});
        run_op("sub_max_max", MAX_A, MAX_A, 1'b1, 514'(0));
        run_op("add_max_max", MAX_A, MAX_A, 1'b0, {{513{1'b1}}, 1'b0});
        run_op("sub_9_4", 513'(9), 513'(4), 1'b1, 514'(5));

        // busy rejection from reset values
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stream("toggle", 0, 41);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        stream("continuous", 1, 41);

        // reset mid-operation: add 5+7, reset sampled at edge T+4
        tick();
        in_a     = 513'(5);
        in_b     = 513'(7);
        subtract = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort result", result, 514'(0));
        check("abort done", {513'b0, done}, 514'(0));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done === 1'b1) seen++;
            end
            check("abort no_done", 514'(seen), 514'(0));
        end
        check("abort result_after", result, 514'(0));
        run_op("add_3_4", 513'(3), 513'(4), 1'b0, 514'(7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_addsub_seq.md
MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter: LIMB_W, 64, limb width in bits; legal values 32, 64, 128.
REQ-003 Derived constants: LIMBS = ceil(514/LIMB_W), which is 9 at the default; EXT = LIMBS*LIMB_W.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  request; sampled only in IDLE.
REQ-007 Port: subtract  input  1  0 = add, 1 = in_a - in_b; captured with start.
REQ-008 Port: in_a  input  513  operand A (unsigned); captured with start.
REQ-009 Port: in_b  input  513  operand B (unsigned); captured with start.
REQ-010 Port: result  output  514  registered sum or difference.
REQ-011 Port: done  output  1  one-cycle completion pulse; result is valid while done=1.

Function
REQ-012 States SHALL be IDLE and CALC, with a limb counter cnt of width ceil(log2(LIMBS)).
REQ-013 In IDLE with start=1 at an edge, the block SHALL:
- zero-extend in_a and in_b to EXT bits and capture them;
- invert captured B if subtract=1;
- set carry = subtract and cnt = 0;
- go to CALC.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE and hold result.
REQ-015 Each CALC edge SHALL compute limb cnt = A_limb + B_limb + carry, store the LIMB_W-bit sum into limb cnt of an internal accumulator, update carry, and increment cnt.
REQ-016 At the CALC edge with cnt = LIMBS-1, the block SHALL:
- load result with bits [513:0] of the completed accumulator (final limb included);
- set done = 1;
- return to IDLE.
REQ-017 done SHALL be 1 for exactly one cycle and 0 at all other times.
REQ-018 Latency: with start sampled at edge T, done SHALL be high between edge T+LIMBS and edge T+LIMBS+1.
- Default: done rises 9 edges after the start edge.
REQ-019 Arithmetic, add: result = in_a + in_b exactly; bit 513 is the carry-out.
REQ-020 Arithmetic, subtract: result = (in_a - in_b) mod 2^514, i.e. a 514-bit two's-complement difference; bit 513 = 1 iff in_a < in_b.
REQ-021 Bits of the accumulator above bit 513 SHALL be discarded.
REQ-022 start in CALC SHALL be ignored; input changes during CALC SHALL NOT affect the operation in progress.
REQ-023 start=1 in the cycle done=1 (state already IDLE) SHALL be accepted at the next edge.
- Back-to-back throughput: one operation per LIMBS+1 cycles.
REQ-024 start held high continuously SHALL cause an operation to be accepted every LIMBS+1 cycles.
REQ-025 result SHALL hold its value from done until the next completion; it SHALL NOT show partial sums.

Reset
REQ-026 When reset=1 at an edge, the block SHALL:
- go to IDLE;
- set done = 0, result = 0, cnt = 0, carry = 0;
- clear captured operands.
REQ-027 Reset SHALL take priority over start and over CALC progress.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-029 A start sampled at the first edge after reset deasserts SHALL be accepted normally.

Verification
REQ-030 Add, in_a=1, in_b=1, start at edge T -> done=1 only in the cycle after edge T+9; result=2.
REQ-031 Full carry ripple: add, in_a=2^513-1, in_b=1 -> result[513]=1 and result[512:0]=0.
REQ-032 Subtract, in_a=0, in_b=1 -> result=2^514-1 (all 514 bits set).
- Subtract, in_a=in_b=2^513-1 -> result=0.
- Add, in_a=in_b=2^513-1 -> result=2^514-2.
REQ-033 Busy rejection: start toggled every cycle, with in_a/in_b/subtract inverted every cycle from reset values 0 ->
- exactly one done per 10 cycles;
- each result matches the operands captured at its accepting edge.
REQ-034 Reset mid-operation: reset pulsed at edge T+4 of an add 5+7 -> no done pulse, result=0; a new add 3+4 afterwards -> result=7 after 9 edges.
